// File: rtl/regfile.sv
// 32-entry register file feeding the EX-stage ALU operands.
// Also latches ALU status flags for branch/compare logic.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic              flag_we,
  input  logic              zero_in,
  input  logic              carry_in,
  input  logic              negative_in,
  input  logic              overflow_in,
  output logic [3:0]        flags
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              fwd1;
  logic              fwd2;

  assign wr_ok = we && (waddr != '0);
  assign fwd1  = BYPASS && wr_ok && (waddr == raddr1);
  assign fwd2  = BYPASS && wr_ok && (waddr == raddr2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 4'b0000;
    end else if (flag_we) begin
      flags <= {overflow_in, negative_in,
                carry_in, zero_in};
    end
  end

  // Reset gating keeps the bypass path from leaking wdata while in reset.
  always_comb begin
    rdata1 = mem[raddr1];
    if (fwd1) begin
      rdata1 = wdata;
    end
    if (!rst_n || raddr1 == '0) begin
      rdata1 = '0;
    end
  end

  always_comb begin
    rdata2 = mem[raddr2];
    if (fwd2) begin
      rdata2 = wdata;
    end
    if (!rst_n || raddr2 == '0) begin
      rdata2 = '0;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: reset, write/read, r0, bypass,
// flag capture and asynchronous reset.
module tb_regfile;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        flag_we;
  logic        zero_in;
  logic        carry_in;
  logic        negative_in;
  logic        overflow_in;

  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [3:0]  flags;
  logic [31:0] nb_rdata1;
  logic [31:0] nb_rdata2;
  logic [3:0]  nb_flags;

  int n_tests;
  int n_fail;

  regfile #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .we(we),
    .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .flag_we(flag_we), .zero_in(zero_in),
    .carry_in(carry_in),
    .negative_in(negative_in),
    .overflow_in(overflow_in),
    .flags(flags)
  );

  regfile #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .we(we),
    .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(nb_rdata1), .rdata2(nb_rdata2),
    .flag_we(flag_we), .zero_in(zero_in),
    .carry_in(carry_in),
    .negative_in(negative_in),
    .overflow_in(overflow_in),
    .flags(nb_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    {overflow_in, negative_in, carry_in, zero_in} = f;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    raddr1  = '0;
    raddr2  = '0;
    flag_we = 1'b0;
    set_flags(4'b0000);

    // T1 reset
    #2;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i);
      raddr2 = 5'(31 - i);
      #1;
      check("t1_rd1", rdata1, 32'h0);
      check("t1_rd2", rdata2, 32'h0);
    end
    check("t1_flags", {28'h0, flags}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // T2 write/read
    @(negedge clk);
    we = 1'b1; waddr = 5'd1; wdata = 32'h0000_0005;
    @(negedge clk);
    waddr = 5'd2; wdata = 32'hffff_000f;
    @(negedge clk);
    we = 1'b0; raddr1 = 5'd1; raddr2 = 5'd2;
    #1;
    check("t2_rd1", rdata1, 32'h0000_0005);
    check("t2_rd2", rdata2, 32'hffff_000f);
    check("t2_nb_rd1", nb_rdata1, 32'h0000_0005);

    // T3 r0 hardwired
    @(negedge clk);
    we = 1'b1; waddr = 5'd0; wdata = 32'hdead_beef;
    raddr1 = 5'd0;
    #1;
    check("t3_byp_r0", rdata1, 32'h0);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("t3_rd_r0", rdata1, 32'h0);
    check("t3_nb_r0", nb_rdata1, 32'h0);

    // T4 bypass
    raddr1 = 5'd1; raddr2 = 5'd3;
    #1;
    check("t4_r3_old", rdata2, 32'h0);
    we = 1'b1; waddr = 5'd3; wdata = 32'h1234_5678;
    #1;
    check("t4_byp", rdata2, 32'h1234_5678);
    check("t4_nobyp", nb_rdata2, 32'h0);
    check("t4_other", rdata1, 32'h0000_0005);
    @(negedge clk);
    we = 1'b0;
    #1;
    check("t4_after", rdata2, 32'h1234_5678);
    check("t4_nb_after", nb_rdata2, 32'h1234_5678);

    // T5 flags, together with a write
    flag_we = 1'b1; set_flags(4'b0110);
    we = 1'b1; waddr = 5'd4; wdata = 32'ha5a5_a5a5;
    @(posedge clk); #1;
    flag_we = 1'b0; set_flags(4'b1001);
    we = 1'b0; waddr = 5'd5; wdata = 32'h5555_aaaa;
    raddr1 = 5'd4; raddr2 = 5'd5;
    #1;
    check("t5_flags", {28'h0, flags}, 32'h6);
    check("t5_wr4", rdata1, 32'ha5a5_a5a5);
    @(posedge clk); #1;
    check("t5_hold", {28'h0, flags}, 32'h6);
    check("t5_we0", rdata2, 32'h0);

    // T6 async reset mid-cycle
    raddr1 = 5'd1; raddr2 = 5'd4;
    @(negedge clk);
    #2;
    check("t6_pre_rd1", rdata1, 32'h5);
    check("t6_pre_flags", {28'h0, flags}, 32'h6);
    rst_n = 1'b0;
    #1;
    check("t6_rd1", rdata1, 32'h0);
    check("t6_rd2", rdata2, 32'h0);
    check("t6_flags", {28'h0, flags}, 32'h0);
    check("t6_nb_flags", {28'h0, nb_flags}, 32'h0);
    we = 1'b1; waddr = 5'd1; wdata = 32'hcafe_f00d;
    flag_we = 1'b1; set_flags(4'b1111);
    #1;
    check("t6_no_byp", rdata1, 32'h0);
    @(posedge clk); #1;
    we = 1'b0; flag_we = 1'b0;
    check("t6_no_flag", {28'h0, flags}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t6_no_wr", rdata1, 32'h0);
    check("t6_no_wr_nb", nb_rdata1, 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
